wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/copperv_pkg.sv | 15 +
 rtl/rr_select.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/copperv_pkg.sv
// copperv_pkg: enums and limits shared by the copperv bus controllers.
// The Wishbone round-robin arbiter imports its state type from here.
package copperv_pkg;

    // Arbiter ownership state: either nobody holds the slave port, or one
    // master has been latched as the owner.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int ARB_MIN_MASTERS = 2;
    localparam int ARB_MAX_MASTERS = 8;

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational rotating first-one picker.
// Ports:
//   req     - request vector, one bit per master
//   pointer - index at which the search starts; the search wraps n-1 -> 0
//   pick    - one-hot of the first requester found, all-zero if none
module rr_select #(
    parameter int n  = 2,
    parameter int pw = (n > 1) ? $clog2(n) : 1
) (
    input  logic [n-1:0]  req,
    input  logic [pw-1:0] pointer,
    output logic [n-1:0]  pick
);

    logic          found;
    logic [pw-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < n; k++) begin
            idx = pw'((int'(pointer) + k) % n);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: shares one Wishbone slave port among m_count masters with
// round-robin priority. Ownership is taken one cycle after a request is seen
// in IDLE and held until the owner drops m_cyc; at least one IDLE cycle
// separates two owners.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   m_cyc/m_stb/m_we      - per-master controls (bit i = master i)
//   m_adr/m_dat_w/m_sel   - per-master address/data/byte-select, slice i = master i
//   m_ack                 - per-master acknowledge (only the owner ever sees it)
//   m_dat_r               - slave read data, broadcast
//   s_*                   - slave-side Wishbone port
//   grant                 - one-hot current owner, zero when idle
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module wb_rr_arbiter
    import copperv_pkg::*;
#(
    parameter int m_count    = 2,
    parameter int addr_width = `BUS_WIDTH,
    parameter int data_width = `BUS_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [m_count-1:0]                m_cyc,
    input  logic [m_count-1:0]                m_stb,
    input  logic [m_count-1:0]                m_we,
    input  logic [m_count*addr_width-1:0]     m_adr,
    input  logic [m_count*data_width-1:0]     m_dat_w,
    input  logic [m_count*data_width/8-1:0]   m_sel,
    output logic [m_count-1:0]                m_ack,
    output logic [data_width-1:0]             m_dat_r,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [addr_width-1:0]             s_adr,
    output logic [data_width-1:0]             s_dat_w,
    output logic [data_width/8-1:0]           s_sel,
    input  logic [data_width-1:0]             s_dat_r,
    input  logic                              s_ack,
    output logic [m_count-1:0]                grant
);

    localparam int sel_width = data_width / 8;
    localparam int pw        = $clog2(m_count);

    arb_state_e         state_q, state_d;
    logic [pw-1:0]      ptr_q, ptr_d;
    logic [pw-1:0]      owner_q, owner_d;
    logic [m_count-1:0] grant_q, grant_d;
    logic [m_count-1:0] pick;
    logic [pw-1:0]      pick_idx;

    rr_select #(
        .n  (m_count),
        .pw (pw)
    ) u_rr_select (
        .req     (m_cyc),
        .pointer (ptr_q),
        .pick    (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < m_count; i++) begin
            if (pick[i]) pick_idx = pw'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    state_d = OWNED;
                    owner_d = pick_idx;
                    grant_d = pick;
                    // Next search starts just above the new owner.
                    ptr_d   = (pick_idx == pw'(m_count - 1)) ? '0 : pick_idx + pw'(1);
                end
            end
            OWNED: begin
                // Other requests are deliberately ignored here; only the
                // owner's release matters, and release always lands in IDLE
                // so the next grant is at least one cycle away.
                if (!m_cyc[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        if (state_q == OWNED) begin
            s_cyc   = m_cyc[owner_q];
            s_stb   = m_stb[owner_q];
            s_we    = m_we[owner_q];
            s_adr   = m_adr[owner_q*addr_width +: addr_width];
            s_dat_w = m_dat_w[owner_q*data_width +: data_width];
            s_sel   = m_sel[owner_q*sel_width +: sel_width];
        end
    end

    // Ack follows the registered grant, so an owner that drops m_cyc in the
    // ack cycle still receives that ack.
    assign m_ack   = grant_q & {m_count{s_ack}};
    assign m_dat_r = s_dat_r;
    assign grant   = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    // Two-master instance
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, grant;
    logic [63:0] m_adr, m_dat_w;
    logic [7:0]  m_sel;
    logic [31:0] m_dat_r, s_adr, s_dat_w, s_dat_r;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;

    // Three-master instance
    logic [2:0]  m_cyc3, m_stb3, m_we3, m_ack3, grant3;
    logic [95:0] m_adr3, m_dat_w3;
    logic [11:0] m_sel3;
    logic [31:0] m_dat_r3, s_adr3, s_dat_w3;
    logic        s_cyc3, s_stb3, s_we3, s_ack3;
    logic [3:0]  s_sel3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    wb_rr_arbiter #(.m_count(2), .addr_width(32), .data_width(32)) dut (
        .clock(clock), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_ack(m_ack), .m_dat_r(m_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant)
    );

    wb_rr_arbiter #(.m_count(3), .addr_width(32), .data_width(32)) dut3 (
        .clock(clock), .reset(reset),
        .m_cyc(m_cyc3), .m_stb(m_stb3), .m_we(m_we3),
        .m_adr(m_adr3), .m_dat_w(m_dat_w3), .m_sel(m_sel3),
        .m_ack(m_ack3), .m_dat_r(m_dat_r3),
        .s_cyc(s_cyc3), .s_stb(s_stb3), .s_we(s_we3),
        .s_adr(s_adr3), .s_dat_w(s_dat_w3), .s_sel(s_sel3),
        .s_dat_r(s_dat_r), .s_ack(s_ack3), .grant(grant3)
    );

    typedef struct packed {
        logic       rst;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic [1:0] e_grant;
        logic       e_scyc;
        logic       e_sstb;
        logic [1:0] e_mack;
        logic [7:0] e_adr;
        logic       e_swe;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst  cyc    stb    ack   grant  scyc  sstb  mack   adr    swe
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'h10, 1'b1};
        vecs[2]  = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'h10, 1'b1};
        vecs[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'h10, 1'b1};
        vecs[6]  = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'h10, 1'b1};
        vecs[7]  = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 8'h20, 1'b0};
        vecs[9]  = '{1'b0, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 8'h20, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'h10, 1'b1};
        vecs[12] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'h10, 1'b1};
        vecs[13] = '{1'b0, 2'b11, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 8'h10, 1'b1};
        vecs[14] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'h10, 1'b1};
        vecs[15] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'h10, 1'b1};
        vecs[16] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 8'h20, 1'b0};
        vecs[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[19] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'h10, 1'b1};
        vecs[20] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'h10, 1'b1};
        vecs[21] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'h10, 1'b1};
        vecs[22] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[23] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};

        reset    = 1'b1;
        m_cyc    = '0; m_stb = '0; m_we = 2'b01;
        m_adr    = {32'h0000_0020, 32'h0000_0010};
        m_dat_w  = {32'h1234_5678, 32'hDEAD_BEEF};
        m_sel    = {4'h3, 4'hF};
        s_dat_r  = 32'hCAFE_F00D;
        s_ack    = 1'b0;
        m_cyc3   = '0; m_stb3 = '0; m_we3 = '0;
        m_adr3   = {32'h300, 32'h200, 32'h100};
        m_dat_w3 = '0;
        m_sel3   = '1;
        s_ack3   = 1'b0;
        tick();

        for (int i = 0; i < 24; i++) begin
            reset = vecs[i].rst;
            m_cyc = vecs[i].cyc;
            m_stb = vecs[i].stb;
            s_ack = vecs[i].ack;
            tick();
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("v%0d_s_cyc", i), 32'(s_cyc), 32'(vecs[i].e_scyc));
            chk($sformatf("v%0d_s_stb", i), 32'(s_stb), 32'(vecs[i].e_sstb));
            chk($sformatf("v%0d_m_ack", i), 32'(m_ack), 32'(vecs[i].e_mack));
            chk($sformatf("v%0d_s_adr", i), s_adr, 32'(vecs[i].e_adr));
            chk($sformatf("v%0d_s_we", i), 32'(s_we), 32'(vecs[i].e_swe));
        end

        // Master 0 write: data path mirrored, read data broadcast.
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        chk("wr_grant", 32'(grant), 32'h1);
        chk("wr_dat_w", s_dat_w, 32'hDEAD_BEEF);
        chk("wr_sel", 32'(s_sel), 32'hF);
        chk("dat_r_bcast", m_dat_r, 32'hCAFE_F00D);

        // Owner drops m_cyc in the ack cycle: ack still reaches it.
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b1;
        #1;
        chk("drop_ack", 32'(m_ack), 32'h1);
        tick();
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_no_ack", 32'(m_ack), 32'h0);
        s_ack = 1'b0;
        tick();

        // Reset during an owned read abandons the transfer.
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00;
        tick();
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_we", 32'(s_we), 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        reset = 1'b0;
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        chk("post_rst_grant", 32'(grant), 32'h2);
        chk("post_rst_adr", s_adr, 32'h20);
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();

        // Three masters, all requesting: order 0,1,2,0 with wrap.
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_cyc3 = 3'b111; m_stb3 = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [2:0] exp_oh;
            exp_oh = 3'b001 << (k % 3);
            chk($sformatf("rr3_grant%0d", k), 32'(grant3), 32'(exp_oh));
            chk($sformatf("rr3_adr%0d", k), s_adr3, 32'h100 * ((k % 3) + 1));
            s_ack3 = 1'b1;
            m_cyc3 = 3'b111 & ~exp_oh;
            m_stb3 = m_cyc3;
            #1;
            chk($sformatf("rr3_ack%0d", k), 32'(m_ack3), 32'(exp_oh));
            tick();
            chk($sformatf("rr3_idle%0d", k), 32'(grant3), 32'h0);
            s_ack3 = 1'b0;
            m_cyc3 = 3'b111; m_stb3 = 3'b111;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
